// File: rtl/ex_stage_if.sv
// Handshake/operand bundle between decode and the execute stage.
// The decoder drives the *_i signals; the execute stage returns results and stallreq_o.
interface ex_stage_if;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    // Handshake: an instruction retires on a rising edge where valid_i=1 and
    // stallreq_o=0; while stallreq_o=1 the decoder holds every *_i signal stable.
    // valid_o is a one-cycle pulse per retired instruction.
    modport master (
        output valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  valid_o, wd_o, wreg_o, wdata_o, stallreq_o
    );
    modport slave (
        input  valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output valid_o, wd_o, wreg_o, wdata_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: logic/arith/move ops, single-cycle MULTU into HI/LO and a
// 32-iteration restoring DIVU that stalls upstream while it runs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus,
    output logic [1:0]  dbg_state
);
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLTU  = 8'h2B;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    localparam logic [2:0] SEL_NOP    = 3'b000;
    localparam logic [2:0] SEL_LOGIC  = 3'b001;
    localparam logic [2:0] SEL_MOVE   = 3'b011;
    localparam logic [2:0] SEL_ARITH  = 3'b100;
    localparam logic [2:0] SEL_MULDIV = 3'b101;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

    state_t      state, state_n;
    logic [31:0] hi, lo;
    logic [31:0] dvd_q, dvs, rem;
    logic [4:0]  cnt;
    logic        div_start, retire;

    logic [31:0] res;
    logic        res_wreg, hilo_we;
    logic [31:0] hi_n, lo_n;
    logic [63:0] prod;
    logic [32:0] trial, diff;
    logic [31:0] rem_step, q_step;

    assign div_start = bus.valid_i && (bus.aluop_i == OP_DIVU) && (bus.reg2_i != 32'd0);
    assign dbg_state = state;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // FSM next state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (div_start) state_n = S_DIV;
            S_DIV:   if (cnt == 5'd31) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.stallreq_o = ((state == S_IDLE) && div_start) || (state == S_DIV);
        retire         = bus.valid_i && !bus.stallreq_o;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        trial    = {rem, dvd_q[31]};
        diff     = trial - {1'b0, dvs};
        rem_step = diff[32] ? trial[31:0] : diff[31:0];
        q_step   = {dvd_q[30:0], ~diff[32]};
    end

    // Result selection for instructions retiring from IDLE.
    always_comb begin
        res      = 32'd0;
        res_wreg = bus.wreg_i;
        hilo_we  = 1'b0;
        hi_n     = hi;
        lo_n     = lo;
        prod     = bus.reg1_i * bus.reg2_i;
        case (bus.alusel_i)
            SEL_NOP: if (bus.aluop_i != OP_NOP) res_wreg = 1'b0;
            SEL_LOGIC: case (bus.aluop_i)
                OP_AND:  res = bus.reg1_i & bus.reg2_i;
                OP_OR:   res = bus.reg1_i | bus.reg2_i;
                OP_XOR:  res = bus.reg1_i ^ bus.reg2_i;
                OP_NOR:  res = ~(bus.reg1_i | bus.reg2_i);
                default: res_wreg = 1'b0;
            endcase
            SEL_ARITH: case (bus.aluop_i)
                OP_ADDU: res = bus.reg1_i + bus.reg2_i;
                OP_SUBU: res = bus.reg1_i - bus.reg2_i;
                OP_SLTU: res = {31'd0, bus.reg1_i < bus.reg2_i};
                default: res_wreg = 1'b0;
            endcase
            SEL_MOVE: case (bus.aluop_i)
                OP_MFHI: res = hi;
                OP_MFLO: res = lo;
                default: res_wreg = 1'b0;
            endcase
            SEL_MULDIV: begin
                res_wreg = 1'b0;
                case (bus.aluop_i)
                    OP_MULTU: begin
                        hilo_we = 1'b1;
                        hi_n    = prod[63:32];
                        lo_n    = prod[31:0];
                    end
                    // Only a zero divisor reaches here: nonzero DIVU stalls instead.
                    OP_DIVU: begin
                        hilo_we = 1'b1;
                        hi_n    = bus.reg1_i;
                        lo_n    = 32'hFFFF_FFFF;
                    end
                    default: ;
                endcase
            end
            default: res_wreg = 1'b0;
        endcase
    end

    // Datapath: output registers, HI/LO and divider working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_o <= 1'b0;
            bus.wreg_o  <= 1'b0;
            bus.wd_o    <= 5'd0;
            bus.wdata_o <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            dvd_q       <= 32'd0;
            dvs         <= 32'd0;
            rem         <= 32'd0;
            cnt         <= 5'd0;
        end else begin
            if (retire) begin
                bus.valid_o <= 1'b1;
                bus.wd_o    <= bus.wd_i;
                // A DONE retire is the held DIVU: it never writes the regfile.
                bus.wreg_o  <= (state == S_DONE) ? 1'b0 : res_wreg;
                bus.wdata_o <= (state == S_DONE) ? 32'd0 : res;
                if ((state == S_IDLE) && hilo_we) begin
                    hi <= hi_n;
                    lo <= lo_n;
                end
            end else begin
                bus.valid_o <= 1'b0;
                bus.wreg_o  <= 1'b0;
            end

            if ((state == S_IDLE) && div_start) begin
                dvd_q <= bus.reg1_i;
                dvs   <= bus.reg2_i;
                rem   <= 32'd0;
                cnt   <= 5'd0;
            end else if (state == S_DIV) begin
                dvd_q <= q_step;
                rem   <= rem_step;
                cnt   <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    lo <= q_step;
                    hi <= rem_step;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: driver pushes expected results into a queue,
// a negedge monitor pops and compares whenever valid_o is seen.
module tb_ex_stage;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ex_stage_if bus ();

    ex_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10, OP_MFLO = 8'h12, OP_MULTU = 8'h19, OP_DIVU = 8'h1B;
    localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_MOVE = 3'b011, SEL_ARITH = 3'b100, SEL_MULDIV = 3'b101;

    // expected entry: {wd[4:0], wreg, wdata[31:0]}
    logic [37:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int stalls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: present one instruction and hold it until it retires
    task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                         input logic exp_wreg, input logic [31:0] exp_wdata, output int nstall);
        int cyc;
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = r1;
        bus.reg2_i   = r2;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
        exp_q.push_back({wd, exp_wreg, exp_wdata});
        nstall = 0;
        cyc    = 0;
        #1;
        while (bus.stallreq_o && cyc < 100) begin
            nstall++;
            cyc++;
            @(negedge clk);
            #1;
        end
        if (cyc >= 100) chk("stall_timeout", 64'(cyc), 64'd0);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // scoreboard monitor
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wd",    64'(bus.wd_o),    64'(e[37:33]));
                    chk("wreg",  64'(bus.wreg_o),  64'(e[32]));
                    chk("wdata", 64'(bus.wdata_o), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.aluop_i  = 8'h00;
        bus.alusel_i = 3'b000;
        bus.reg1_i   = 32'd0;
        bus.reg2_i   = 32'd0;
        bus.wd_i     = 5'd0;
        bus.wreg_i   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_wreg",  64'(bus.wreg_o),  64'd0);
        chk("rst_wd",    64'(bus.wd_o),    64'd0);
        chk("rst_wdata", 64'(bus.wdata_o), 64'd0);
        chk("rst_stall", 64'(bus.stallreq_o), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;

        issue(OP_OR,  SEL_LOGIC, 32'h0000_1100, 32'h0000_0020, 5'd3, 1'b1, 1'b1, 32'h0000_1120, stalls);
        issue(OP_AND, SEL_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 1'b1, 1'b1, 32'h00F0_1234, stalls);
        issue(OP_XOR, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd5, 1'b1, 1'b1, 32'hF00F_F00F, stalls);
        issue(OP_NOR, SEL_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd6, 1'b1, 1'b1, 32'hFF00_0000, stalls);
        issue(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1, 1'b1, 32'd1, stalls);
        issue(OP_SUBU, SEL_ARITH, 32'd0, 32'd1, 5'd8, 1'b1, 1'b1, 32'hFFFF_FFFF, stalls);
        issue(OP_SLTU, SEL_ARITH, 32'd5, 32'd7, 5'd9, 1'b1, 1'b1, 32'd1, stalls);
        idle();
        @(negedge clk);
        chk("idle_valid", 64'(bus.valid_o), 64'd0);
        chk("idle_wreg",  64'(bus.wreg_o),  64'd0);
        chk("hold_wdata", 64'(bus.wdata_o), 64'd1);
        chk("hold_wd",    64'(bus.wd_o),    64'd9);

        // MULTU then MFHI/MFLO back to back
        issue(OP_MULTU, SEL_MULDIV, 32'hFFFF_FFFF, 32'd2, 5'd10, 1'b1, 1'b0, 32'd0, stalls);
        chk("multu_stall", 64'(stalls), 64'd0);
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd11, 1'b1, 1'b1, 32'd1, stalls);
        chk("mfhi_stall", 64'(stalls), 64'd0);
        issue(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd12, 1'b1, 1'b1, 32'hFFFF_FFFE, stalls);

        // unknown combination: no regfile write, HI/LO untouched
        issue(OP_ADDU, SEL_LOGIC, 32'd3, 32'd4, 5'd13, 1'b1, 1'b0, 32'd0, stalls);
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd14, 1'b1, 1'b1, 32'd1, stalls);

        // DIVU 100/7
        issue(OP_DIVU, SEL_MULDIV, 32'd100, 32'd7, 5'd15, 1'b1, 1'b0, 32'd0, stalls);
        chk("divu_stall_cycles", 64'(stalls), 64'd33);
        issue(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd16, 1'b1, 1'b1, 32'd14, stalls);
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd17, 1'b1, 1'b1, 32'd2, stalls);

        // DIVU by zero
        issue(OP_DIVU, SEL_MULDIV, 32'd9, 32'd0, 5'd18, 1'b1, 1'b0, 32'd0, stalls);
        chk("div0_stall", 64'(stalls), 64'd0);
        issue(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd19, 1'b1, 1'b1, 32'hFFFF_FFFF, stalls);
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd20, 1'b1, 1'b1, 32'd9, stalls);

        // DIVU aborted by reset at iteration 10
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.aluop_i  = OP_DIVU;
        bus.alusel_i = SEL_MULDIV;
        bus.reg1_i   = 32'd1000;
        bus.reg2_i   = 32'd3;
        bus.wd_i     = 5'd21;
        bus.wreg_i   = 1'b1;
        repeat (11) @(negedge clk);
        chk("mid_div_state", 64'(dbg_state), 64'd1);
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", 64'(dbg_state), 64'd0);
        chk("abort_stall", 64'(bus.stallreq_o), 64'd0);
        chk("abort_valid", 64'(bus.valid_o), 64'd0);
        issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd22, 1'b1, 1'b1, 32'd0, stalls);
        issue(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd23, 1'b1, 1'b1, 32'd0, stalls);
        idle();

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
